mem_stage_lsu: RTL and testbench

//  Parametrised pipeline memory stage (M) with M/W pipeline register and a load/store unit.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/lsu_align.sv | 68 ++++++
 rtl/mem_stage_lsu.sv | 99 +++++++++
 tb/tb_mem_stage_lsu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the M stage: funct3 encodings, result-select codes and FSM states.
package mem_stage_pkg;

   typedef enum logic [2:0] {
      Lb  = 3'b000,
      Lh  = 3'b001,
      Lw  = 3'b010,
      Ld  = 3'b011,
      Lbu = 3'b100,
      Lhu = 3'b101,
      Lwu = 3'b110
   } load_f3_e;

   typedef enum logic [2:0] {
      Sb = 3'b000,
      Sh = 3'b001,
      Sw = 3'b010,
      Sd = 3'b011
   } store_f3_e;

   localparam logic [1:0] ResultAlu  = 2'b00;
   localparam logic [1:0] ResultLoad = 2'b01;
   localparam logic [1:0] ResultPc4  = 2'b10;

   typedef enum logic [0:0] {
      StIdle     = 1'b0,
      StWaitResp = 1'b1
   } lsu_state_e;

   // log2 of the access size in bytes
   function automatic logic [1:0] access_size(input logic [2:0] f3);
      return f3[1:0];
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, load extraction and extension,
// plus detection of misaligned or unsupported access sizes.
module lsu_align
   import mem_stage_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   localparam int unsigned BE_W  = XLEN / 8,
   localparam int unsigned OFF_W = $clog2(BE_W)
) (
   input  logic             is_store,
   input  logic [2:0]       funct3,
   input  logic [OFF_W-1:0] off,
   input  logic [XLEN-1:0]  wdata_in,
   input  logic [XLEN-1:0]  rdata_in,
   output logic [XLEN-1:0]  store_data,
   output logic [BE_W-1:0]  be,
   output logic [XLEN-1:0]  load_data,
   output logic             bad
);

   logic [1:0]      size;
   logic [BE_W-1:0] mask;
   logic [XLEN-1:0] shifted;
   logic            unsigned_ld;

   always_comb begin
      size        = access_size(funct3);
      unsigned_ld = funct3[2];

      if (is_store) begin
         bad = funct3[2] | ((size == 2'd3) && (XLEN == 32));
      end else begin
         bad = (funct3 == 3'b111) ||
               ((load_f3_e'(funct3) inside {Ld, Lwu}) && (XLEN == 32));
      end

      case (size)
         2'd1:    bad = bad | off[0];
         2'd2:    bad = bad | (off[1:0] != 2'b00);
         2'd3:    bad = bad | (off != '0);
         default: ;
      endcase

      case (size)
         2'd0:    store_data = {BE_W{wdata_in[7:0]}};
         2'd1:    store_data = {(BE_W / 2){wdata_in[15:0]}};
         2'd2:    store_data = {(XLEN / 32){wdata_in[31:0]}};
         default: store_data = wdata_in;
      endcase

      case (size)
         2'd0:    mask = BE_W'(1);
         2'd1:    mask = BE_W'(3);
         2'd2:    mask = BE_W'(15);
         default: mask = '1;
      endcase
      be = mask << off;

      shifted = rdata_in >> {off, 3'b000};
      case (size)
         2'd0: load_data = unsigned_ld ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
         2'd1: load_data = unsigned_ld ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
         2'd2: load_data = unsigned_ld ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: data-memory handshake FSM, stall generation and the M/W register.
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32,
   localparam int unsigned BE_W  = XLEN / 8,
   localparam int unsigned OFF_W = $clog2(BE_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic              MemWriteM,
   input  logic [2:0]        Funct3M,
   input  logic [XLEN-1:0]   ALUResultM,
   input  logic [XLEN-1:0]   WriteDataM,
   input  logic [4:0]        RdM,
   input  logic [XLEN-1:0]   PCPlus4M,
   output logic              StallM,
   output logic              MisalignM,
   output logic              RegWriteW,
   output logic [1:0]        ResultSrcW,
   output logic [XLEN-1:0]   ALUResultW,
   output logic [XLEN-1:0]   ReadDataW,
   output logic [4:0]        RdW,
   output logic [XLEN-1:0]   PCPlus4W,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [BE_W-1:0]   dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata
);

   lsu_state_e      state_q;
   logic            is_load, access, bad, legal, load_done;
   logic [XLEN-1:0] load_data;

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .is_store   (MemWriteM),
      .funct3     (Funct3M),
      .off        (ALUResultM[OFF_W-1:0]),
      .wdata_in   (WriteDataM),
      .rdata_in   (dmem_rdata),
      .store_data (dmem_wdata),
      .be         (dmem_be),
      .load_data  (load_data),
      .bad        (bad)
   );

   always_comb begin
      is_load   = !MemWriteM && (ResultSrcM == ResultLoad);
      access    = MemWriteM || (ResultSrcM == ResultLoad);
      legal     = access && !bad;
      MisalignM = (state_q == StIdle) && access && bad;
      dmem_req  = (state_q == StIdle) && legal;
      dmem_we   = dmem_req && MemWriteM;
      dmem_addr = ADDR_W'(ALUResultM) & ~ADDR_W'(BE_W - 1);
      load_done = (state_q == StWaitResp) && dmem_rvalid;
      // Stores are posted on ready; loads always stall until rvalid.
      StallM    = (dmem_req && (!dmem_ready || is_load)) ||
                  ((state_q == StWaitResp) && !dmem_rvalid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         RdW        <= '0;
         PCPlus4W   <= '0;
      end else begin
         case (state_q)
            StIdle:     if (dmem_req && dmem_ready && is_load) state_q <= StWaitResp;
            StWaitResp: if (dmem_rvalid) state_q <= StIdle;
            default:    state_q <= StIdle;
         endcase

         if (StallM) begin
            RegWriteW <= 1'b0;
         end else begin
            RegWriteW  <= RegWriteM && !MisalignM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            if (load_done) ReadDataW <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single-cycle vectors plus hand-built load sequences.
module tb_mem_stage_lsu;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        rw, mw, stall, mis, rw_w, req, we, ready, rvalid;
   logic [1:0]  rsrc, rsrc_w;
   logic [2:0]  f3;
   logic [31:0] alu, wd, pc4, alu_w, rd_w_data, pc4_w, addr, wdat, rdata;
   logic [4:0]  rd, rd_w;
   logic [3:0]  be;

   // 64-bit instance signals
   logic        d_rw, d_mw, d_stall, d_mis, d_rw_w, d_req, d_we, d_ready, d_rvalid;
   logic [1:0]  d_rsrc, d_rsrc_w;
   logic [2:0]  d_f3;
   logic [63:0] d_alu, d_wd, d_pc4, d_alu_w, d_rdw, d_pc4_w, d_wdat, d_rdata;
   logic [31:0] d_addr;
   logic [4:0]  d_rd, d_rd_w;
   logic [7:0]  d_be;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
      .clk(clk), .rst(rst), .RegWriteM(rw), .ResultSrcM(rsrc), .MemWriteM(mw), .Funct3M(f3),
      .ALUResultM(alu), .WriteDataM(wd), .RdM(rd), .PCPlus4M(pc4), .StallM(stall),
      .MisalignM(mis), .RegWriteW(rw_w), .ResultSrcW(rsrc_w), .ALUResultW(alu_w),
      .ReadDataW(rd_w_data), .RdW(rd_w), .PCPlus4W(pc4_w), .dmem_req(req), .dmem_we(we),
      .dmem_addr(addr), .dmem_be(be), .dmem_wdata(wdat), .dmem_ready(ready),
      .dmem_rvalid(rvalid), .dmem_rdata(rdata)
   );

   mem_stage_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst), .RegWriteM(d_rw), .ResultSrcM(d_rsrc), .MemWriteM(d_mw),
      .Funct3M(d_f3), .ALUResultM(d_alu), .WriteDataM(d_wd), .RdM(d_rd), .PCPlus4M(d_pc4),
      .StallM(d_stall), .MisalignM(d_mis), .RegWriteW(d_rw_w), .ResultSrcW(d_rsrc_w),
      .ALUResultW(d_alu_w), .ReadDataW(d_rdw), .RdW(d_rd_w), .PCPlus4W(d_pc4_w),
      .dmem_req(d_req), .dmem_we(d_we), .dmem_addr(d_addr), .dmem_be(d_be),
      .dmem_wdata(d_wdat), .dmem_ready(d_ready), .dmem_rvalid(d_rvalid), .dmem_rdata(d_rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f, input logic [1:0] s, input logic m, input logic r,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst);
      f3 = f; rsrc = s; mw = m; rw = r; alu = a; wd = d; rd = dst; pc4 = a + 32'd4;
   endtask

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [1:0]  rsrc;
      logic        mw;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        req;
      logic [3:0]  be;
      logic [31:0] wdat;
      logic        mis;
      logic        rw_w;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      vecs[0] = '{"sw",      3'b010, 2'b00, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[1] = '{"sb",      3'b000, 2'b00, 1'b1, 1'b0, 32'h102, 32'h000000A5, 1'b1, 4'b0100, 32'hA5A5A5A5, 1'b0, 1'b0};
      vecs[2] = '{"sh",      3'b001, 2'b00, 1'b1, 1'b0, 32'h102, 32'h00001234, 1'b1, 4'b1100, 32'h12341234, 1'b0, 1'b0};
      vecs[3] = '{"lw_mis",  3'b010, 2'b01, 1'b0, 1'b1, 32'h101, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 1'b0};
      vecs[4] = '{"alu",     3'b000, 2'b00, 1'b0, 1'b1, 32'h055, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 1'b1};
      vecs[5] = '{"sh_mis",  3'b001, 2'b00, 1'b1, 1'b0, 32'h101, 32'h1234,     1'b0, 4'b0000, 32'h0,        1'b1, 1'b0};
      vecs[6] = '{"ld_ill",  3'b011, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 1'b0};
      vecs[7] = '{"lwu_ill", 3'b110, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 1'b0};
      vecs[8] = '{"pc4",     3'b000, 2'b10, 1'b0, 1'b1, 32'h200, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 1'b1};

      drive(3'b000, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      ready = 1'b0; rvalid = 1'b0; rdata = '0;
      d_f3 = '0; d_rsrc = '0; d_mw = 1'b0; d_rw = 1'b0; d_alu = '0; d_wd = '0; d_rd = '0;
      d_pc4 = '0; d_ready = 1'b0; d_rvalid = 1'b0; d_rdata = '0;

      // Reset state
      #12;
      chk("rst_rw_w", rw_w, 0);
      chk("rst_readdata", rd_w_data, 0);
      chk("rst_req", req, 0);
      chk("rst_stall", stall, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Table-driven single-cycle accesses with ready asserted
      ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].f3, vecs[i].rsrc, vecs[i].mw, vecs[i].rw, vecs[i].addr, vecs[i].wd, 5'd3);
         #3;
         chk({vecs[i].name, "_req"}, req, vecs[i].req);
         chk({vecs[i].name, "_stall"}, stall, 0);
         chk({vecs[i].name, "_mis"}, mis, vecs[i].mis);
         if (vecs[i].req) begin
            chk({vecs[i].name, "_be"}, be, vecs[i].be);
            chk({vecs[i].name, "_wdata"}, wdat, vecs[i].wdat);
            chk({vecs[i].name, "_addr"}, addr, vecs[i].addr & 32'hFFFF_FFFC);
            chk({vecs[i].name, "_we"}, we, 1);
         end
         @(posedge clk); #1;
         chk({vecs[i].name, "_rw_w"}, rw_w, vecs[i].rw_w);
         chk({vecs[i].name, "_alu_w"}, alu_w, vecs[i].addr);
      end

      // LB @0x103: ready now, rvalid next cycle, exactly one stall cycle
      drive(3'b000, 2'b01, 1'b0, 1'b1, 32'h103, 32'h0, 5'd9);
      ready = 1'b1; rvalid = 1'b0;
      #3 chk("lb_req", req, 1);
      chk("lb_stall_ready", stall, 1);
      @(posedge clk); #1;
      chk("lb_bubble", rw_w, 0);
      ready = 1'b0; rvalid = 1'b1; rdata = 32'h80FF_FF00;
      #3 chk("lb_stall_rvalid", stall, 0);
      chk("lb_no_req", req, 0);
      @(posedge clk); #1;
      rvalid = 1'b0;
      chk("lb_data", rd_w_data, 32'hFFFF_FF80);
      chk("lb_rw_w", rw_w, 1);
      chk("lb_rd_w", rd_w, 9);

      // LHU @0x102: ready low for 3 cycles, then ready, then rvalid
      drive(3'b101, 2'b01, 1'b0, 1'b1, 32'h102, 32'h0, 5'd11);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         ready = (c == 3); rvalid = (c == 4); rdata = 32'h80FF_1234;
         #3;
         if (c <= 3) begin
            chk("lhu_req", req, 1);
            chk("lhu_addr", addr, 32'h100);
            chk("lhu_be", be, 4'b1100);
         end
         if (!stall) break;
         cnt++;
         @(posedge clk); #1;
      end
      chk("lhu_stall_cycles", cnt, 4);
      @(posedge clk); #1;
      ready = 1'b0; rvalid = 1'b0;
      chk("lhu_data", rd_w_data, 32'h0000_80FF);

      // Reset while waiting for a load response
      drive(3'b010, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0, 5'd4);
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      drive(3'b000, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_stall", stall, 0);
      chk("midrst_readdata", rd_w_data, 0);
      chk("midrst_rw_w", rw_w, 0);
      @(posedge clk); #1 rst = 1'b0;
      rvalid = 1'b1; rdata = 32'h1234_5678;
      #3 chk("late_rvalid_stall", stall, 0);
      @(posedge clk); #1;
      chk("late_rvalid_data", rd_w_data, 0);
      // Still IDLE: a new load with ready low must request and stall despite rvalid
      drive(3'b010, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0, 5'd4);
      #3 chk("post_rst_req", req, 1);
      chk("post_rst_stall", stall, 1);
      @(posedge clk); #1;
      rvalid = 1'b0; ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      rvalid = 1'b0;
      drive(3'b000, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("post_rst_lw_data", rd_w_data, 32'hCAFE_F00D);

      // 64-bit: SD @0x8, then LWU @0xC
      d_f3 = 3'b011; d_rsrc = 2'b00; d_mw = 1'b1; d_alu = 64'h8;
      d_wd = 64'h0123_4567_89AB_CDEF; d_ready = 1'b1;
      #3 chk("sd_be", d_be, 8'hFF);
      chk("sd_addr", d_addr, 32'h8);
      chk("sd_wdata", d_wdat, 64'h0123_4567_89AB_CDEF);
      chk("sd_stall", d_stall, 0);
      @(posedge clk); #1;
      d_f3 = 3'b110; d_rsrc = 2'b01; d_mw = 1'b0; d_rw = 1'b1; d_alu = 64'hC; d_rd = 5'd7;
      #3 chk("lwu_req", d_req, 1);
      chk("lwu_mis", d_mis, 0);
      chk("lwu_be", d_be, 8'hF0);
      @(posedge clk); #1;
      d_ready = 1'b0; d_rvalid = 1'b1; d_rdata = 64'hFFFF_FFFF_0000_0000;
      @(posedge clk); #1;
      d_rvalid = 1'b0;
      chk("lwu_data", d_rdw, 64'h0000_0000_FFFF_FFFF);
      chk("lwu_rw_w", d_rw_w, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
